// File: rtl/ysyx_idu_stage.sv
// RV32I decode stage: one-entry {pc, inst} register behind a valid/ready
// handshake, with all decode derived combinationally from the held word.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         drop held entry and block this cycle's accept
//   prev_valid, ready_o           upstream handshake
//   pc_i, inst_i                  fetched pc and instruction word
//   valid_o, next_ready           downstream handshake
//   pc_o, inst_o                  registered pc and instruction word
//   rd, rs1, rs2                  raw register index fields
//   imm                           sign-extended immediate for the format
//   alu_op                        {funct7[5] or 0, funct3}
//   rd_wen, mem_ren, mem_wen      GPR write, load, store
//   is_branch, is_jump, is_system instruction class flags
//   illegal                       undecodable instruction
module ysyx_idu_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        alu_op,
  output logic              rd_wen,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              is_branch,
  output logic              is_jump,
  output logic              is_system,
  output logic              illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic   valid_q;
  logic   valid_d;
  entry_t entry_q;
  entry_t entry_d;
  logic   accept;
  logic   handoff;

  // Handshake
  assign ready_o = !valid_q | next_ready;
  assign accept  = prev_valid & ready_o & !flush;
  assign handoff = valid_q & next_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d      = 1'b1;
      entry_d.pc   = pc_i;
      entry_d.inst = inst_i;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  // Decode of the held word
  logic [DATA_W-1:0] iw;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;

  assign iw  = entry_q.inst;
  assign opc = iw[6:0];
  assign f3  = iw[14:12];
  assign f7  = iw[31:25];

  logic op_lui;
  logic op_auipc;
  logic op_jal;
  logic op_jalr;
  logic op_branch;
  logic op_load;
  logic op_store;
  logic op_opimm;
  logic op_op;
  logic op_system;

  assign op_lui    = opc == OPC_LUI;
  assign op_auipc  = opc == OPC_AUIPC;
  assign op_jal    = opc == OPC_JAL;
  assign op_jalr   = opc == OPC_JALR;
  assign op_branch = opc == OPC_BRANCH;
  assign op_load   = opc == OPC_LOAD;
  assign op_store  = opc == OPC_STORE;
  assign op_opimm  = opc == OPC_OPIMM;
  assign op_op     = opc == OPC_OP;
  assign op_system = opc == OPC_SYSTEM;

  logic known;
  logic f7_ok;
  logic ill;
  logic writes_rd;

  assign known = op_lui | op_auipc | op_jal
               | op_jalr | op_branch | op_load
               | op_store | op_opimm | op_op
               | op_system;

  assign f7_ok = (f7 == 7'b0000000)
               | (f7 == 7'b0100000);

  assign ill = (iw[1:0] != 2'b11)
             | !known
             | (op_op & !f7_ok);

  assign writes_rd = op_op | op_opimm | op_load
                   | op_lui | op_auipc
                   | op_jal | op_jalr;

  assign pc_o    = entry_q.pc;
  assign inst_o  = entry_q.inst;
  assign valid_o = valid_q;
  assign rd      = iw[11:7];
  assign rs1     = iw[19:15];
  assign rs2     = iw[24:20];

  // Immediate, one format per opcode class
  always_comb begin
    imm = '0;
    unique case (1'b1)
      op_opimm, op_load, op_jalr:
        imm = {{(DATA_W-12){iw[31]}},
               iw[31:20]};
      op_store:
        imm = {{(DATA_W-12){iw[31]}},
               iw[31:25], iw[11:7]};
      op_branch:
        imm = {{(DATA_W-12){iw[31]}},
               iw[7], iw[30:25],
               iw[11:8], 1'b0};
      op_lui, op_auipc:
        imm = {{(DATA_W-31){iw[31]}},
               iw[30:12], 12'b0};
      op_jal:
        imm = {{(DATA_W-20){iw[31]}},
               iw[19:12], iw[20],
               iw[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // Only shifts-right in OP-IMM carry the arithmetic bit
  always_comb begin
    alu_op = 4'b0000;
    if (op_op) begin
      alu_op = {iw[30], f3};
    end else if (op_opimm) begin
      alu_op = {(f3 == 3'b101) & iw[30], f3};
    end
  end

  logic live;
  assign live = valid_q & !ill;

  assign rd_wen    = live & writes_rd
                   & (iw[11:7] != 5'd0);
  assign mem_ren   = live & op_load;
  assign mem_wen   = live & op_store;
  assign is_branch = live & op_branch;
  assign is_jump   = live & (op_jal | op_jalr);
  assign is_system = valid_q & op_system;
  assign illegal   = valid_q & ill;

endmodule

// File: tb/tb_ysyx_idu_stage.sv
// Directed bench for ysyx_idu_stage: reset, decode table,
// backpressure, flush and mid-operation reset.
module tb_ysyx_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        valid_o;
  logic        next_ready;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        rd_wen;
  logic        mem_ren;
  logic        mem_wen;
  logic        is_branch;
  logic        is_jump;
  logic        is_system;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_idu_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .prev_valid(prev_valid), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .valid_o(valid_o), .next_ready(next_ready),
    .pc_o(pc_o), .inst_o(inst_o),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_op(alu_op),
    .rd_wen(rd_wen), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .is_branch(is_branch),
    .is_jump(is_jump), .is_system(is_system),
    .illegal(illegal)
  );

  // {rd_wen, mem_ren, mem_wen, is_branch, is_jump, is_system, illegal}
  logic [6:0] flg;
  assign flg = {rd_wen, mem_ren, mem_wen, is_branch,
                is_jump, is_system, illegal};

  localparam int N = 17;
  logic [31:0] t_inst [N];
  logic [31:0] t_imm  [N];
  logic [3:0]  t_alu  [N];
  logic [6:0]  t_flg  [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc,
                       input logic [31:0] ins);
    prev_valid = 1'b1;
    pc_i       = pc;
    inst_i     = ins;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; prev_valid = 1'b0;
    next_ready = 1'b1; pc_i = '0; inst_i = '0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, pc_o, inst_o} !== 65'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b pc=%h i=%h want 0/0/0",
               valid_o, pc_o, inst_o);
    end
    checks++;
    if ({ready_o, flg} !== 8'b1_0000000) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b flg=%b want 1/0000000",
               ready_o, flg);
    end
  endtask

  task automatic test_decode();
    t_inst = '{32'h00500093, 32'hFE20AE23, 32'h008000EF,
               32'h00000863, 32'hFE209EE3, 32'h123452B7,
               32'h402081B3, 32'h4021D193, 32'h00812283,
               32'h00000073, 32'h00000013, 32'h00000000,
               32'h0000007F, 32'h021080B3, 32'hFFF100E7,
               32'hFFF3F313, 32'h40000093};
    t_imm  = '{32'h00000005, 32'hFFFFFFFC, 32'h00000008,
               32'h00000010, 32'hFFFFFFFC, 32'h12345000,
               32'h00000000, 32'h00000402, 32'h00000008,
               32'h00000000, 32'h00000000, 32'h00000000,
               32'h00000000, 32'h00000000, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'h00000400};
    t_alu  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
               4'h8, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h7, 4'h0};
    t_flg  = '{7'b1000000, 7'b0010000, 7'b1000100,
               7'b0001000, 7'b0001000, 7'b1000000,
               7'b1000000, 7'b1000000, 7'b1100000,
               7'b0000010, 7'b0000000, 7'b0000001,
               7'b0000001, 7'b0000001, 7'b1000100,
               7'b1000000, 7'b1000000};
    next_ready = 1'b1;
    offer(32'h1000, t_inst[0]);
    for (int i = 0; i < N; i++) begin
      step();
      if (i + 1 < N) offer(32'h1000 + 32'(4 * (i + 1)), t_inst[i + 1]);
      else prev_valid = 1'b0;
      checks++;
      if ({valid_o, pc_o, inst_o} !==
          {1'b1, 32'h1000 + 32'(4 * i), t_inst[i]}) begin
        errors++;
        $display("FAIL dec_entry[%0d] got v=%b pc=%h i=%h want 1/%h/%h",
                 i, valid_o, pc_o, inst_o,
                 32'h1000 + 32'(4 * i), t_inst[i]);
      end
      checks++;
      if ({rd, rs1, rs2} !==
          {t_inst[i][11:7], t_inst[i][19:15], t_inst[i][24:20]}) begin
        errors++;
        $display("FAIL dec_regs[%0d] got %0d/%0d/%0d", i, rd, rs1, rs2);
      end
      checks++;
      if (imm !== t_imm[i]) begin
        errors++;
        $display("FAIL dec_imm[%0d] got %h want %h", i, imm, t_imm[i]);
      end
      checks++;
      if (alu_op !== t_alu[i]) begin
        errors++;
        $display("FAIL dec_alu[%0d] got %b want %b", i, alu_op, t_alu[i]);
      end
      checks++;
      if (flg !== t_flg[i]) begin
        errors++;
        $display("FAIL dec_flags[%0d] got %b want %b", i, flg, t_flg[i]);
      end
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL dec_drain got v=%b want 0", valid_o);
    end
  endtask

  task automatic test_back_to_back_stall();
    next_ready = 1'b0;
    offer(32'h100, 32'h00500093);
    step();
    offer(32'h104, 32'h4021D193);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({valid_o, ready_o, pc_o, inst_o, imm} !==
          {2'b10, 32'h100, 32'h00500093, 32'h5}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b r=%b pc=%h i=%h imm=%h",
                 k, valid_o, ready_o, pc_o, inst_o, imm);
      end
      if (k < 2) step();
    end
    next_ready = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_passthru_ready got %b want 1", ready_o);
    end
    step();
    prev_valid = 1'b0;
    checks++;
    if ({valid_o, pc_o, inst_o, alu_op} !==
        {1'b1, 32'h104, 32'h4021D193, 4'hD}) begin
      errors++;
      $display("FAIL stall_second got v=%b pc=%h i=%h alu=%b want 1/104/4021d193/1101",
               valid_o, pc_o, inst_o, alu_op);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got v=%b want 0", valid_o);
    end
  endtask

  task automatic test_flush();
    next_ready = 1'b0;
    offer(32'h200, 32'h00500093);
    step();
    offer(32'h204, 32'h008000EF);
    next_ready = 1'b1;
    flush      = 1'b1;
    #1;
    checks++;
    if ({valid_o, ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL flush_ready got v=%b r=%b want 1/1", valid_o, ready_o);
    end
    step();
    flush      = 1'b0;
    prev_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({valid_o, flg} !== 8'd0) begin
        errors++;
        $display("FAIL flush_drop[%0d] got v=%b flg=%b pc=%h want 0/0000000",
                 k, valid_o, flg, pc_o);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    next_ready = 1'b0;
    offer(32'h300, 32'h00500093);
    step();
    prev_valid = 1'b0;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b want 1", valid_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({valid_o, pc_o, inst_o, rd_wen} !== 66'd0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%b pc=%h i=%h w=%b want 0",
               valid_o, pc_o, inst_o, rd_wen);
    end
    next_ready = 1'b1;
    offer(32'h400, 32'hFE20AE23);
    step();
    prev_valid = 1'b0;
    checks++;
    if ({valid_o, pc_o, imm, flg} !==
        {1'b1, 32'h400, 32'hFFFFFFFC, 7'b0010000}) begin
      errors++;
      $display("FAIL rstmid_after got v=%b pc=%h imm=%h flg=%b",
               valid_o, pc_o, imm, flg);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain got v=%b want 0", valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
